// File: rtl/d_debounce.sv
// -----------------------------------------------------------------------------
// d_debounce
//   Turns a raw, asynchronous level (switch or pin) into a clean, clock-aligned
//   level for the d input of the downstream d_latch stage.
//   - d_in is passed through a SYNC_STAGES flop chain.
//   - A 4-state FSM with a dwell counter filters glitches. A change is accepted
//     only after STABLE_CYCLES consecutive equal synchronised samples.
//   - A one-cycle rise or fall pulse is emitted on each accepted transition.
//
// Parameters
//   SYNC_STAGES    synchroniser depth (>= 2)
//   STABLE_CYCLES  equal samples needed to accept a change (>= 1)
//
// Ports
//   clk   in   rising-edge clock
//   rst   in   synchronous, active-low reset
//   en    in   filter enable; while low, pending candidates are dropped
//   d_in  in   raw input, asynchronous to clk
//   out   out  debounced level (registered)
//   rise  out  one-cycle pulse when out goes 0->1 (registered)
//   fall  out  one-cycle pulse when out goes 1->0 (registered)
//   busy  out  high while a candidate transition is being qualified
// -----------------------------------------------------------------------------
module d_debounce #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic d_in,
  output logic out,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  // With a single required sample there is nothing to dwell on: a stable
  // state jumps straight to the opposite stable state.
  localparam bit SINGLE = (STABLE_CYCLES == 1);

  typedef enum logic [1:0] {
    S_LOW      = 2'd0,
    S_RISE_CHK = 2'd1,
    S_HIGH     = 2'd2,
    S_FALL_CHK = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   out_q, out_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   busy_q, busy_d;
  logic                   sync_lvl;

  // The synchroniser keeps shifting regardless of en.
  assign sync_d   = {sync_q[SYNC_STAGES-2:0], d_in};
  assign sync_lvl = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;

    case (state_q)
      S_LOW: begin
        if (en && sync_lvl) begin
          if (SINGLE) begin
            state_d = S_HIGH;
            cnt_d   = '0;
            out_d   = 1'b1;
            rise_d  = 1'b1;
          end else begin
            state_d = S_RISE_CHK;
            cnt_d   = CNT_ONE;
          end
        end
      end

      S_RISE_CHK: begin
        // Disable or a returning 0 both discard the candidate silently.
        if (!en || !sync_lvl) begin
          state_d = S_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_HIGH;
          cnt_d   = '0;
          out_d   = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_HIGH: begin
        if (en && !sync_lvl) begin
          if (SINGLE) begin
            state_d = S_LOW;
            cnt_d   = '0;
            out_d   = 1'b0;
            fall_d  = 1'b1;
          end else begin
            state_d = S_FALL_CHK;
            cnt_d   = CNT_ONE;
          end
        end
      end

      S_FALL_CHK: begin
        if (!en || sync_lvl) begin
          state_d = S_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_LOW;
          cnt_d   = '0;
          out_d   = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = S_LOW;
        cnt_d   = '0;
      end
    endcase

    // busy is registered, so it is derived from the state being entered.
    busy_d = (state_d == S_RISE_CHK) || (state_d == S_FALL_CHK);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q  <= '0;
      state_q <= S_LOW;
      cnt_q   <= '0;
      out_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
    end
  end

  assign out  = out_q;
  assign rise = rise_q;
  assign fall = fall_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_d_debounce.sv
module tb_d_debounce;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en, d_in, d_in2;
  logic out, rise, fall, busy;
  logic out2, rise2, fall2, busy2;

  d_debounce dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .d_in (d_in),
    .out  (out),
    .rise (rise),
    .fall (fall),
    .busy (busy)
  );

  d_debounce #(.SYNC_STAGES(3), .STABLE_CYCLES(1)) dut2 (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .d_in (d_in2),
    .out  (out2),
    .rise (rise2),
    .fall (fall2),
    .busy (busy2)
  );

  // exp packs {out, rise, fall, busy} as seen just after the edge.
  typedef struct {
    logic       rst;
    logic       en;
    logic       d;
    logic [3:0] exp;
    int         test;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;
  int   cur_test = 0;

  function automatic void push(input logic r, input logic e, input logic d,
                               input logic [3:0] x);
    vec_t v;
    v.rst  = r;
    v.en   = e;
    v.d    = d;
    v.exp  = x;
    v.test = cur_test;
    vecs.push_back(v);
  endfunction

  // Clean 0->1 from S_LOW with an all-zero chain: out rises at edge 5.
  function automatic void rise_seq();
    push(1, 1, 1, 4'b0000);
    push(1, 1, 1, 4'b0000);
    push(1, 1, 1, 4'b0001);
    push(1, 1, 1, 4'b0001);
    push(1, 1, 1, 4'b0001);
    push(1, 1, 1, 4'b1100);
    push(1, 1, 1, 4'b1000);
  endfunction

  // Clean 1->0 from S_HIGH with an all-one chain: out falls at edge 5.
  function automatic void fall_seq();
    push(1, 1, 0, 4'b1000);
    push(1, 1, 0, 4'b1000);
    push(1, 1, 0, 4'b1001);
    push(1, 1, 0, 4'b1001);
    push(1, 1, 0, 4'b1001);
    push(1, 1, 0, 4'b0010);
    push(1, 1, 0, 4'b0000);
  endfunction

  task automatic step2(input logic d, input logic [3:0] x, input int idx);
    logic [3:0] got;
    d_in2 = d;
    @(posedge clk);
    #1;
    got = {out2, rise2, fall2, busy2};
    total++;
    if (got !== x) begin
      bad++;
      $display("FAIL dut2_step%0d got=%b want=%b", idx, got, x);
    end
  endtask

  initial begin
    logic [3:0] got;
    logic       dd;
    logic       bb;
    rst   = 1'b0;
    en    = 1'b1;
    d_in  = 1'b0;
    d_in2 = 1'b0;

    // Test 1: reset held three edges with d_in=1, then released with d_in=0.
    cur_test = 1;
    repeat (3) push(0, 1, 1, 4'b0000);
    push(1, 1, 0, 4'b0000);
    push(1, 1, 0, 4'b0000);

    // Test 2: clean rise, then bring it back down.
    cur_test = 2;
    rise_seq();
    fall_seq();

    // Test 3: single-cycle pulses, ten of them, then two flush cycles.
    cur_test = 3;
    for (int i = 0; i < 22; i++) begin
      dd = (i < 20) && (i % 2 == 0);
      bb = (i >= 2) && (i - 2 < 20) && ((i - 2) % 2 == 0);
      push(1, 1, dd, {3'b000, bb});
    end

    // Test 4: high 3, low 1, high 10 -> first candidate rejected.
    cur_test = 4;
    push(1, 1, 1, 4'b0000);
    push(1, 1, 1, 4'b0000);
    push(1, 1, 1, 4'b0001);
    push(1, 1, 0, 4'b0001);
    push(1, 1, 1, 4'b0001);
    push(1, 1, 1, 4'b0000);
    push(1, 1, 1, 4'b0001);
    push(1, 1, 1, 4'b0001);
    push(1, 1, 1, 4'b0001);
    push(1, 1, 1, 4'b1100);
    repeat (4) push(1, 1, 1, 4'b1000);
    fall_seq();

    // Test 5: en dropped for one edge while cnt==2, then requalification.
    cur_test = 5;
    push(1, 1, 1, 4'b0000);
    push(1, 1, 1, 4'b0000);
    push(1, 1, 1, 4'b0001);
    push(1, 1, 1, 4'b0001);
    push(1, 0, 1, 4'b0000);
    push(1, 1, 1, 4'b0001);
    push(1, 1, 1, 4'b0001);
    push(1, 1, 1, 4'b0001);
    push(1, 1, 1, 4'b1100);
    push(1, 1, 1, 4'b1000);
    fall_seq();

    // Test 7: en low in a stable state holds it, then enabling qualifies.
    cur_test = 7;
    repeat (5) push(1, 0, 1, 4'b0000);
    push(1, 1, 1, 4'b0001);
    push(1, 1, 1, 4'b0001);
    push(1, 1, 1, 4'b0001);
    push(1, 1, 1, 4'b1100);
    push(1, 1, 1, 4'b1000);

    // Test 6: reset during S_FALL_CHK -> out=0 with no fall pulse.
    cur_test = 6;
    push(1, 1, 0, 4'b1000);
    push(1, 1, 0, 4'b1000);
    push(1, 1, 0, 4'b1001);
    push(0, 1, 0, 4'b0000);
    push(1, 1, 0, 4'b0000);
    push(1, 1, 0, 4'b0000);

    for (int i = 0; i < vecs.size(); i++) begin
      rst  = vecs[i].rst;
      en   = vecs[i].en;
      d_in = vecs[i].d;
      @(posedge clk);
      #1;
      got = {out, rise, fall, busy};
      total++;
      if (got !== vecs[i].exp) begin
        bad++;
        $display("FAIL vec%0d test%0d {out,rise,fall,busy} got=%b want=%b",
                 i, vecs[i].test, got, vecs[i].exp);
      end
    end

    // Test 6b: SYNC_STAGES=3, STABLE_CYCLES=1 -> out changes at edge 3.
    rst  = 1'b1;
    en   = 1'b1;
    d_in = 1'b0;
    step2(1'b1, 4'b0000, 0);
    step2(1'b1, 4'b0000, 1);
    step2(1'b1, 4'b0000, 2);
    step2(1'b1, 4'b1100, 3);
    step2(1'b1, 4'b1000, 4);
    step2(1'b0, 4'b1000, 5);
    step2(1'b0, 4'b1000, 6);
    step2(1'b0, 4'b1000, 7);
    step2(1'b0, 4'b0010, 8);
    step2(1'b0, 4'b0000, 9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
